// File: rtl/lcd_win_ctrl.sv
// LCD window controller: loads an IMG_W x IMG_H image serially, then streams a
// WIN_W x WIN_H window of it with movable origin and optional horizontal mirror.
module lcd_win_ctrl #(
    parameter int DW    = 8,
    parameter int IMG_W = 6,
    parameter int IMG_H = 6,
    parameter int WIN_W = 3,
    parameter int WIN_H = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DW-1:0]              datain,
    input  logic [2:0]                 cmd,
    input  logic                       cmd_valid,
    output logic [DW-1:0]              dataout,
    output logic                       output_valid,
    output logic                       busy,
    output logic [$clog2(IMG_H)-1:0]   org_row,
    output logic [$clog2(IMG_W)-1:0]   org_col
);

    localparam int N  = IMG_W * IMG_H;
    localparam int M  = WIN_W * WIN_H;
    localparam int AW = $clog2(N) + 1;
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    localparam logic [RW-1:0] ROW_HOME = RW'((IMG_H - WIN_H + 1) / 2);
    localparam logic [CW-1:0] COL_HOME = CW'((IMG_W - WIN_W + 1) / 2);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - WIN_H);
    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - WIN_W);

    localparam logic [AW-1:0] LOAD_LAST = AW'(N - 1);
    localparam logic [AW-1:0] REF_END   = AW'(M);
    localparam logic [AW-1:0] WIN_W_A   = AW'(WIN_W);
    localparam logic [AW-1:0] IMG_W_A   = AW'(IMG_W);
    localparam logic [AW-1:0] ONE_A     = AW'(1);

    localparam logic [2:0] CMD_REFRESH = 3'd0;
    localparam logic [2:0] CMD_LOAD    = 3'd1;
    localparam logic [2:0] CMD_RIGHT   = 3'd2;
    localparam logic [2:0] CMD_LEFT    = 3'd3;
    localparam logic [2:0] CMD_UP      = 3'd4;
    localparam logic [2:0] CMD_DOWN    = 3'd5;
    localparam logic [2:0] CMD_MIRROR  = 3'd6;
    localparam logic [2:0] CMD_HOME    = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_REFRESH = 2'd2,
        S_MOVE    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   r_row;
    logic [AW-1:0]   r_col;
    logic [RW-1:0]   r_org_row;
    logic [CW-1:0]   r_org_col;
    logic            r_flip;
    logic [2:0]      r_cmd;
    logic [DW-1:0]   r_dout;
    logic            r_ovalid;
    logic [DW-1:0]   r_buf [N];

    logic            w_accept;
    logic [AW-1:0]   w_col_eff;
    logic [IW-1:0]   w_rd_idx;
    logic [IW-1:0]   w_wr_idx;

    assign w_accept  = (r_state == S_IDLE) && cmd_valid;
    assign w_col_eff = r_flip ? (WIN_W_A - ONE_A - r_col) : r_col;
    // Full-width sum; saturated origin keeps it inside the buffer, so truncation is safe.
    assign w_rd_idx  = IW'((AW'(r_org_row) + r_row) * IMG_W_A + AW'(r_org_col) + w_col_eff);
    assign w_wr_idx  = IW'(r_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd)
                        CMD_REFRESH: w_next = S_REFRESH;
                        CMD_LOAD:    w_next = S_LOAD;
                        default:     w_next = S_MOVE;
                    endcase
                end
            end
            S_LOAD:    if (r_cnt == LOAD_LAST) w_next = S_IDLE;
            S_REFRESH: if (r_cnt == REF_END)   w_next = S_IDLE;
            S_MOVE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_org_row <= ROW_HOME;
            r_org_col <= COL_HOME;
            r_flip    <= 1'b0;
            r_cmd     <= CMD_REFRESH;
            r_dout    <= '0;
            r_ovalid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        r_row <= '0;
                        r_col <= '0;
                        r_cmd <= cmd;
                    end
                end
                S_LOAD: r_cnt <= r_cnt + ONE_A;
                S_REFRESH: begin
                    if (r_cnt == REF_END) begin
                        r_ovalid <= 1'b0;
                    end else begin
                        r_dout   <= r_buf[w_rd_idx];
                        r_ovalid <= 1'b1;
                        r_cnt    <= r_cnt + ONE_A;
                        if (r_col == WIN_W_A - ONE_A) begin
                            r_col <= '0;
                            r_row <= r_row + ONE_A;
                        end else begin
                            r_col <= r_col + ONE_A;
                        end
                    end
                end
                S_MOVE: begin
                    case (r_cmd)
                        CMD_RIGHT:  if (r_org_col < COL_MAX) r_org_col <= r_org_col + 1'b1;
                        CMD_LEFT:   if (r_org_col != '0)     r_org_col <= r_org_col - 1'b1;
                        CMD_UP:     if (r_org_row != '0)     r_org_row <= r_org_row - 1'b1;
                        CMD_DOWN:   if (r_org_row < ROW_MAX) r_org_row <= r_org_row + 1'b1;
                        CMD_MIRROR: r_flip <= ~r_flip;
                        CMD_HOME: begin
                            r_org_row <= ROW_HOME;
                            r_org_col <= COL_HOME;
                            r_flip    <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Image memory is deliberately not reset; a partial load keeps what it wrote.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD) r_buf[w_wr_idx] <= datain;
    end

    assign dataout      = r_dout;
    assign output_valid = r_ovalid;
    assign busy         = (r_state != S_IDLE);
    assign org_row      = r_org_row;
    assign org_col      = r_org_col;

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Directed bench for lcd_win_ctrl: load a ramp image, then check window streams
// after shifts, mirror, home, ignored commands and a reset mid-stream.
module tb_lcd_win_ctrl;

    localparam int DW = 8;
    localparam int N  = 36;
    localparam int M  = 9;

    logic          clk;
    logic          reset;
    logic [DW-1:0] datain;
    logic [2:0]    cmd;
    logic          cmd_valid;
    logic [DW-1:0] dataout;
    logic          output_valid;
    logic          busy;
    logic [2:0]    org_row;
    logic [2:0]    org_col;

    int checks   = 0;
    int failures = 0;

    lcd_win_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .datain       (datain),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .dataout      (dataout),
        .output_valid (output_valid),
        .busy         (busy),
        .org_row      (org_row),
        .org_col      (org_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // Drive a command at a negedge; returns at the negedge following the accept edge.
    task automatic send_cmd(input logic [2:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_load();
        send_cmd(3'd1);
        check("load_busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            datain = DW'(i);
            @(negedge clk);
        end
        check("load_busy_end", 32'(busy), 32'd0);
    endtask

    task automatic do_move(input logic [2:0] c);
        send_cmd(c);
        check("move_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("move_done", 32'(busy), 32'd0);
    endtask

    // ev holds the expected pixels, first pixel in the top byte.
    // inject_at: pulse SHIFT_DOWN during the stream; abort_at: reset after that pixel.
    task automatic do_refresh(input string tag, input logic [M*8-1:0] ev,
                              input int inject_at, input int abort_at);
        int busy_cycles;
        logic [7:0] e;
        busy_cycles = 0;
        send_cmd(3'd0);
        if (busy) busy_cycles++;
        for (int k = 0; k < M; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            e = ev[(M-1-k)*8 +: 8];
            if (busy) busy_cycles++;
            check({tag, "_valid"}, 32'(output_valid), 32'd1);
            check({tag, "_pix"}, 32'(dataout), 32'(e));
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                check("rst_valid", 32'(output_valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_dout", 32'(dataout), 32'd0);
                check("rst_row", 32'(org_row), 32'd2);
                check("rst_col", 32'(org_col), 32'd2);
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                return;
            end
            if (k == inject_at) begin
                cmd       = 3'd5;
                cmd_valid = 1'b1;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_end_valid"}, 32'(output_valid), 32'd0);
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(dataout), 32'(ev[7:0]));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd10);
    endtask

    localparam logic [M*8-1:0] EXP_HOME  = {8'd14, 8'd15, 8'd16, 8'd20, 8'd21, 8'd22, 8'd26, 8'd27, 8'd28};
    localparam logic [M*8-1:0] EXP_RIGHT = {8'd15, 8'd16, 8'd17, 8'd21, 8'd22, 8'd23, 8'd27, 8'd28, 8'd29};
    localparam logic [M*8-1:0] EXP_MIRR  = {8'd17, 8'd16, 8'd15, 8'd23, 8'd22, 8'd21, 8'd29, 8'd28, 8'd27};
    localparam logic [M*8-1:0] EXP_ZERO  = {8'd0, 8'd1, 8'd2, 8'd6, 8'd7, 8'd8, 8'd12, 8'd13, 8'd14};

    initial begin
        reset     = 1'b1;
        datain    = '0;
        cmd       = 3'd0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(output_valid), 32'd0);
        check("reset_dout", 32'(dataout), 32'd0);
        check("reset_row", 32'(org_row), 32'd2);
        check("reset_col", 32'(org_col), 32'd2);
        reset = 1'b0;
        @(negedge clk);

        do_load();
        check("load_row", 32'(org_row), 32'd2);
        check("load_col", 32'(org_col), 32'd2);
        do_refresh("ref_home", EXP_HOME, -1, -1);

        for (int i = 0; i < 3; i++) do_move(3'd2);
        check("right_sat_col", 32'(org_col), 32'd3);
        do_refresh("ref_right", EXP_RIGHT, -1, -1);

        do_move(3'd6);
        do_refresh("ref_mirror", EXP_MIRR, -1, -1);

        do_move(3'd7);
        check("home_row", 32'(org_row), 32'd2);
        check("home_col", 32'(org_col), 32'd2);
        do_refresh("ref_home2", EXP_HOME, -1, -1);

        for (int i = 0; i < 3; i++) do_move(3'd4);
        for (int i = 0; i < 3; i++) do_move(3'd3);
        check("zero_row", 32'(org_row), 32'd0);
        check("zero_col", 32'(org_col), 32'd0);
        do_refresh("ref_zero", EXP_ZERO, -1, -1);

        for (int i = 0; i < 4; i++) do_move(3'd5);
        check("down_sat_row", 32'(org_row), 32'd3);
        do_move(3'd7);

        // Command held across the busy-falling edge: only the first is taken.
        cmd       = 3'd3;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("held_busy", 32'(busy), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_busy_fall", 32'(busy), 32'd0);
        check("held_col", 32'(org_col), 32'd1);
        do_move(3'd7);

        do_refresh("ref_inject", EXP_HOME, 3, -1);
        check("inject_row", 32'(org_row), 32'd2);
        check("inject_col", 32'(org_col), 32'd2);

        do_refresh("ref_abort", EXP_HOME, -1, 4);
        do_refresh("ref_after_rst", EXP_HOME, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
